// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART transmit arbiter.
//   state_t      : arbiter FSM state encoding
//   NREQ_DEFAULT : default number of byte requesters
package uart_pkg;

    localparam int unsigned NREQ_DEFAULT = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_WRITE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick -- combinational pointer-based round-robin picker.
// Ports:
//   req    in  N   request vector
//   ptr    in  PW  index where the search starts (wraps modulo N)
//   winner out N   one-hot first requester at or after ptr; zero if none
//   any    out 1   high when any request bit is set
module rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic          any
);

    int unsigned idx;
    logic        found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = (32'(ptr) + off) % N;
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
        any = found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter -- round-robin arbiter letting NREQ byte requesters share
// one UART transmitter core.
// Ports:
//   clk        in  1       system clock (rising edge)
//   reset      in  1       asynchronous active-high reset
//   req_valid  in  NREQ    per-requester byte available
//   req_data   in  8*NREQ  per-requester byte, slice i = [8i+7:8i]
//   req_last   in  NREQ    end-of-message flag (lock build only)
//   req_ready  out NREQ    one-hot accept pulse, only in ARB
//   uart_data  out 8       byte held for the transmitter core
//   uart_wr    out 1       single-cycle write strobe
//   uart_busy  in  1       transmitter busy flag
//   grant      out NREQ    one-hot current owner, zero when idle
//   active     out 1       high whenever the FSM is not IDLE
// Build option: define UART_ARB_LOCK_EN to keep ownership with a requester
// until it transfers a byte flagged with req_last.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        uart_data,
    output logic              uart_wr,
    input  logic              uart_busy,
    output logic [NREQ-1:0]   grant,
    output logic              active
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state, state_n;
    logic [NREQ-1:0] grant_n;
    logic [PW-1:0]   last_served, last_served_n;
    logic [7:0]      uart_data_n;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gidx;
    logic [NREQ-1:0] cand;
    logic [NREQ-1:0] winner;
    logic            any;

`ifdef UART_ARB_LOCK_EN
    logic locked, locked_n;

    // While locked only the last-served requester may compete.
    always_comb begin
        cand = req_valid;
        if (locked) begin
            cand = req_valid & (NREQ'(1) << last_served);
        end
    end
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign cand        = req_valid;
`endif

    always_comb begin
        if (last_served == PW'(NREQ - 1)) begin
            ptr = '0;
        end else begin
            ptr = last_served + 1'b1;
        end
    end

    rr_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_pick (
        .req    (cand),
        .ptr    (ptr),
        .winner (winner),
        .any    (any)
    );

    always_comb begin
        gidx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gidx = PW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            grant       <= '0;
            last_served <= PW'(NREQ - 1);
            uart_data   <= '0;
        end else begin
            state       <= state_n;
            grant       <= grant_n;
            last_served <= last_served_n;
            uart_data   <= uart_data_n;
        end
    end

`ifdef UART_ARB_LOCK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            locked <= 1'b0;
        end else begin
            locked <= locked_n;
        end
    end
`endif

    always_comb begin
        state_n       = state;
        grant_n       = grant;
        last_served_n = last_served;
        uart_data_n   = uart_data;
`ifdef UART_ARB_LOCK_EN
        locked_n      = locked;
`endif
        case (state)
            ST_IDLE: begin
                if (any && !uart_busy) begin
                    grant_n = winner;
                    state_n = ST_ARB;
                end
            end
            ST_ARB: begin
                if (req_valid[gidx]) begin
                    uart_data_n   = req_data[8*gidx +: 8];
                    last_served_n = gidx;
`ifdef UART_ARB_LOCK_EN
                    locked_n      = !req_last[gidx];
`endif
                    state_n       = ST_WRITE;
                end else begin
                    // Cancelled: pointer and lock stay as they were.
                    grant_n = '0;
                    state_n = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_n = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (uart_busy) begin
                    state_n = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!uart_busy) begin
                    grant_n = '0;
                    state_n = ST_IDLE;
                end
            end
            default: begin
                grant_n = '0;
                state_n = ST_IDLE;
            end
        endcase
    end

    assign req_ready = (state == ST_ARB) ? grant : '0;
    assign uart_wr   = (state == ST_WRITE);
    assign active    = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter -- directed self-checking bench for uart_tx_arbiter
// with NREQ=2. The lock scenario is compiled in only with UART_ARB_LOCK_EN.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [7:0]  uart_data;
    logic        uart_wr;
    logic        uart_busy;
    logic [1:0]  grant;
    logic        active;

    int unsigned errors = 0;
    int unsigned checks = 0;

    uart_tx_arbiter #(.NREQ(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .uart_data (uart_data),
        .uart_wr   (uart_wr),
        .uart_busy (uart_busy),
        .grant     (grant),
        .active    (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_last  = '0;
        uart_busy = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    // Acts as the transmitter core for one byte: waits for the strobe,
    // checks the byte, runs a busy pulse and returns with the FSM in IDLE.
    task automatic serve(input string tag, input logic [7:0] exp, output logic [1:0] g);
        int unsigned n;
        logic        seen;
        seen = 1'b0;
        n    = 0;
        g    = '0;
        while (!seen && n < 20) begin
            if (uart_wr) seen = 1'b1;
            else begin
                step();
                n++;
            end
        end
        check({tag, " wr seen"}, 32'(seen), 32'd1);
        if (seen) begin
            g = grant;
            check({tag, " data"}, 32'(uart_data), 32'(exp));
            uart_busy = 1'b1;
            step();
            check({tag, " wr single"}, 32'(uart_wr), 32'd0);
            step();
            check({tag, " data held"}, 32'(uart_data), 32'(exp));
            uart_busy = 1'b0;
            step();
            check({tag, " grant cleared"}, 32'(grant), 32'd0);
        end
    endtask

    logic [1:0]  g;
    logic [1:0]  prev_g;
    int unsigned bad;

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        uart_busy = 1'b0;
        #2;
        check("rst active", 32'(active), 32'd0);
        check("rst grant", 32'(grant), 32'd0);
        check("rst ready", 32'(req_ready), 32'd0);
        check("rst wr", 32'(uart_wr), 32'd0);
        check("rst data", 32'(uart_data), 32'd0);
        do_reset();

        // Single requester, cycle-exact latency.
        req_data  = 16'h22A5;
        req_valid = 2'b01;
        step();
        check("single arb grant", 32'(grant), 32'd1);
        check("single arb ready", 32'(req_ready), 32'd1);
        check("single arb wr", 32'(uart_wr), 32'd0);
        step();
        req_valid = 2'b00;
        check("single write wr", 32'(uart_wr), 32'd1);
        check("single write ready", 32'(req_ready), 32'd0);
        serve("single", 8'hA5, g);
        check("single back idle", 32'(active), 32'd0);

        // Fairness with both requesters continuously valid.
        do_reset();
        req_data  = 16'h2211;
        req_valid = 2'b11;
        prev_g    = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            serve("fair", (k % 2 == 0) ? 8'h11 : 8'h22, g);
            if (k > 0) check("fair alternate", 32'(g != prev_g), 32'd1);
            prev_g = g;
        end
        req_valid = 2'b00;
        step();

        // Busy hold: nothing is arbitrated while the core is busy.
        do_reset();
        uart_busy = 1'b1;
        req_valid = 2'b10;
        bad       = 0;
        for (int unsigned k = 0; k < 100; k++) begin
            step();
            if (active || req_ready != 2'b00) bad++;
        end
        check("busy hold", bad, 0);
        uart_busy = 1'b0;
        step();
        check("busy release grant", 32'(grant), 32'd2);
        check("busy release ready", 32'(req_ready), 32'd2);
        serve("busy", 8'h22, g);
        req_valid = 2'b00;
        step();

        // Cancel: valid withdrawn during ARB.
        do_reset();
        req_valid = 2'b01;
        step();
        check("cancel arb ready", 32'(req_ready), 32'd1);
        req_valid = 2'b00;
        step();
        check("cancel idle", 32'(active), 32'd0);
        check("cancel grant", 32'(grant), 32'd0);
        bad = 0;
        for (int unsigned k = 0; k < 5; k++) begin
            if (uart_wr) bad++;
            step();
        end
        check("cancel no wr", bad, 0);
        req_valid = 2'b11;
        step();
        check("cancel next winner", 32'(grant), 32'd1);
        serve("cancel", 8'h11, g);
        req_valid = 2'b00;
        step();

        // Reset asserted in WAIT_DONE.
        do_reset();
        req_valid = 2'b01;
        step();
        step();
        req_valid = 2'b00;
        check("rwd wr", 32'(uart_wr), 32'd1);
        uart_busy = 1'b1;
        step();
        step();
        check("rwd in wait", 32'(active), 32'd1);
        reset     = 1'b1;
        uart_busy = 1'b0;
        #1;
        check("rwd async active", 32'(active), 32'd0);
        check("rwd async grant", 32'(grant), 32'd0);
        step();
        check("rwd data", 32'(uart_data), 32'd0);
        check("rwd ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        bad   = 0;
        for (int unsigned k = 0; k < 5; k++) begin
            step();
            if (uart_wr || active) bad++;
        end
        check("rwd no reoffer", bad, 0);
        req_valid = 2'b11;
        step();
        check("rwd next winner", 32'(grant), 32'd1);
        serve("rwd", 8'h11, g);
        req_valid = 2'b00;
        step();

`ifdef UART_ARB_LOCK_EN
        // Lock: requester 1 keeps ownership until its last byte.
        do_reset();
        req_data  = 16'h3111;
        req_last  = 2'b00;
        req_valid = 2'b10;
        serve("lock b0", 8'h31, g);
        req_valid = 2'b11;
        req_data  = 16'h3211;
        serve("lock b1", 8'h32, g);
        check("lock b1 owner", 32'(g), 32'd2);
        req_data  = 16'h3311;
        req_last  = 2'b10;
        serve("lock b2", 8'h33, g);
        check("lock b2 owner", 32'(g), 32'd2);
        req_valid = 2'b01;
        req_last  = 2'b00;
        serve("lock release", 8'h11, g);
        check("lock release owner", 32'(g), 32'd1);
        req_valid = 2'b00;
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 2, number of byte requesters sharing one UART transmitter (2..8).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  NREQ  per-requester byte-available flag.
REQ-005 req_data  input  8*NREQ  per-requester byte; slice i = bits [8i+7:8i].
REQ-006 req_last  input  NREQ  per-requester end-of-message flag; used only under UART_ARB_LOCK_EN.
REQ-007 req_ready  output  NREQ  one-hot accept pulse; byte i taken when req_valid[i] and req_ready[i] are both high.
REQ-008 uart_data  output  8  byte presented to the transmitter core.
REQ-009 uart_wr  output  1  single-cycle write strobe to the transmitter core.
REQ-010 uart_busy  input  1  transmitter busy flag from the core.
REQ-011 grant  output  NREQ  one-hot current owner; all-zero when idle.
REQ-012 active  output  1  high in every state except IDLE.

Function
REQ-013 FSM states SHALL be IDLE, ARB, WRITE, WAIT_BUSY, WAIT_DONE.
REQ-014 IDLE: when any req_valid is high and uart_busy is low, register the round-robin winner into grant and go to ARB; otherwise stay in IDLE.
REQ-015 Round robin: search starts at index (last_served+1) mod NREQ and takes the first valid requester; last_served resets to NREQ-1, so requester 0 has first priority.
REQ-016 ARB: req_ready[grant] high for exactly this one cycle; if req_valid[grant] is high, capture the data slice into uart_data, update last_served, go to WRITE.
REQ-017 ARB with req_valid[grant] low: cancel the transfer, leave last_served unchanged, clear grant, return to IDLE.
REQ-018 WRITE: uart_wr high for exactly one cycle; go to WAIT_BUSY.
REQ-019 WAIT_BUSY: stay until uart_busy is high, then go to WAIT_DONE.
REQ-020 WAIT_DONE: stay until uart_busy is low, then clear grant and go to IDLE.
REQ-021 uart_data SHALL stay stable from WRITE through the exit from WAIT_DONE.
REQ-022 Minimum latency is 2 cycles from a valid sampled in IDLE to uart_wr (IDLE, ARB, then WRITE).
REQ-023 At most one req_ready bit is ever high; req_ready is never high outside ARB.
REQ-024 Requester valid changes outside ARB SHALL have no effect on the current transfer.

Reset
REQ-025 Reset SHALL asynchronously force: state IDLE, uart_wr 0, uart_data 8'h00, grant 0, req_ready 0, active 0, last_served NREQ-1, lock released.
REQ-026 Reset asserted mid-transfer SHALL abandon the byte with no further uart_wr; the byte is not re-offered.

Configuration
REQ-027 Macro UART_ARB_LOCK_EN, when defined: after a byte transferred with req_last[grant]=0, the arbiter stays locked to that requester, and IDLE considers only that requester until a byte with req_last=1 is transferred.
REQ-028 Lock behaviour: if the locked requester drops valid, the arbiter waits in IDLE; other requesters are not served. A cancelled ARB (REQ-017) keeps the lock.
REQ-029 Without UART_ARB_LOCK_EN: req_last is ignored and every byte is re-arbitrated.

Structure
REQ-030 Shared package uart_pkg SHALL hold the FSM state enum typedef and the NREQ default constant.
REQ-031 The pointer-based round-robin picker SHALL be a combinational sub-module named rr_pick (inputs: request vector, pointer; output: one-hot winner plus any flag).

Verification
REQ-032 Single requester: req_valid[0]=1, data 8'hA5, uart_busy idle -> req_ready[0] one pulse, uart_wr pulses 2 cycles after IDLE sample, uart_data=8'hA5.
REQ-033 Fairness, NREQ=2, both valid continuously, data 8'h11 and 8'h22 -> uart_data sequence 11,22,11,22; no requester served twice in a row.
REQ-034 Busy hold: uart_busy held high 100 cycles with req_valid[1]=1 -> no ARB and no req_ready until busy falls.
REQ-035 Cancel: req_valid[0] drops during ARB -> no uart_wr, state back to IDLE, next winner is still requester 0.
REQ-036 Lock (UART_ARB_LOCK_EN): requester 1 sends 3 bytes with last=0,0,1 while requester 0 is valid -> all 3 bytes from requester 1 are sent before any byte from requester 0.
REQ-037 Reset in WAIT_DONE -> all outputs at reset values next cycle; the following request goes to requester 0.
